// File: rtl/fp_conv_pkg.sv
// Shared definitions for the float-to-fixed conversion blocks.
// Holds FP32 field widths, the exponent bias, the input class encoding,
// flag bit positions, rounding-mode codes and a small classifier helper.
package fp_conv_pkg;

  localparam int unsigned FpWidth    = 32;
  localparam int unsigned FpExpBits  = 8;
  localparam int unsigned FpMantBits = 23;
  localparam int          FpBias     = 127;

  typedef enum logic [1:0] {
    ClsZero,  // zero or subnormal, both flush to 0
    ClsNorm,
    ClsInf,
    ClsNan
  } fp_class_e;

  // Bit positions inside the 3-bit {invalid, overflow, underflow} flag word.
  localparam int unsigned FlagInvalid   = 2;
  localparam int unsigned FlagOverflow  = 1;
  localparam int unsigned FlagUnderflow = 0;

  localparam logic RndNearestEven = 1'b0;
  localparam logic RndTowardZero  = 1'b1;

  function automatic fp_class_e fp_classify(input logic [FpExpBits-1:0]  exp_f,
                                            input logic [FpMantBits-1:0] mant_f);
    if (exp_f == '0) begin
      return ClsZero;
    end else if (exp_f == '1) begin
      return (mant_f == '0) ? ClsInf : ClsNan;
    end else begin
      return ClsNorm;
    end
  endfunction

endpackage

// File: rtl/float_to_fixed_pipe_if.sv
// Stream interface for float_to_fixed_pipe.
// Input side : in_valid, in_ready, in_data (FP32), rnd_mode (0 = RNE, 1 = toward zero).
// Output side: out_valid, out_ready, out_data (W bits), out_flags {invalid, overflow, underflow}.
// master: the environment (drives inputs, consumes results); slave: the converter.
interface float_to_fixed_pipe_if #(
  parameter int unsigned W = 22
) ();
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          rnd_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_flags;

  modport master (
    output in_valid, in_data, rnd_mode, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, rnd_mode, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/fp_round_sat.sv
// Combinational round / negate / saturate stage.
// Takes an unsigned magnitude with guard and sticky bits and produces a W-bit fixed result.
// Ports:
//   sign, mag[W-1:0], guard, sticky : aligned magnitude and rounding bits
//   ovf_in   : magnitude already known to exceed range (or infinity)
//   nan      : input is NaN, result forced to 0 with invalid flag
//   normal   : input was a normal number (qualifies underflow)
//   rnd_mode : 0 = round-nearest-even, 1 = truncate toward zero
//   data     : W-bit result, flags : {invalid, overflow, underflow}
// Build option: FLT2FIX_SIGN_MAG_EN selects sign-magnitude output instead of two's complement.
module fp_round_sat
  import fp_conv_pkg::*;
#(
  parameter int unsigned W = 22
) (
  input  logic         sign,
  input  logic [W-1:0] mag,
  input  logic         guard,
  input  logic         sticky,
  input  logic         ovf_in,
  input  logic         nan,
  input  logic         normal,
  input  logic         rnd_mode,
  output logic [W-1:0] data,
  output logic [2:0]   flags
);

  // 2^(W-1) and 2^(W-1)-1 on W+1 bits.
  localparam logic [W:0] HalfRange = {2'b01, {(W-1){1'b0}}};
  localparam logic [W:0] MagMax    = HalfRange - 1'b1;

  logic       inc;
  logic [W:0] mag_r;
  logic [W:0] limit;
  logic       ovf;

  always_comb begin
    inc   = (rnd_mode == RndNearestEven) && guard && (sticky || mag[0]);
    mag_r = {1'b0, mag} + {{W{1'b0}}, inc};
`ifdef FLT2FIX_SIGN_MAG_EN
    limit = MagMax;
`else
    // Two's complement reaches one step further on the negative side.
    limit = sign ? HalfRange : MagMax;
`endif
    ovf   = ovf_in || (mag_r > limit);

    data  = '0;
    flags = '0;
    if (nan) begin
      flags[FlagInvalid] = 1'b1;
    end else if (ovf) begin
      flags[FlagOverflow] = 1'b1;
`ifdef FLT2FIX_SIGN_MAG_EN
      data = {sign, {(W-1){1'b1}}};
`else
      data = sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    end else begin
`ifdef FLT2FIX_SIGN_MAG_EN
      data = {sign, mag_r[W-2:0]};
`else
      data = sign ? -mag_r[W-1:0] : mag_r[W-1:0];
`endif
      flags[FlagUnderflow] = normal && (mag_r == '0);
    end
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Streaming IEEE-754 single-precision to fixed-point converter, 3 register stages.
//   S1: unpack and classify, compute the alignment shift
//   S2: align the mantissa, capture guard/sticky and coarse overflow
//   S3: round, negate, saturate (fp_round_sat) into the output register
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards everything in flight
//   bus   : float_to_fixed_pipe_if slave modport (valid/ready in and out, data, rnd_mode, flags)
// All stages advance together whenever the output register is empty or being consumed.
// Build option: FLT2FIX_SIGN_MAG_EN selects sign-magnitude output (see fp_round_sat).
module float_to_fixed_pipe
  import fp_conv_pkg::*;
#(
  parameter int unsigned INT_BITS  = 1,
  parameter int unsigned FRAC_BITS = 20
) (
  input logic                 clk,
  input logic                 rst_n,
  float_to_fixed_pipe_if.slave bus
);

  localparam int unsigned W  = 1 + INT_BITS + FRAC_BITS;
  localparam int unsigned WW = W + 24;
  localparam logic signed [9:0] ShiftOfs =
    10'(int'(FRAC_BITS) - FpBias - int'(FpMantBits));
  localparam logic signed [9:0] WSigned  = 10'(W);

  logic advance;

  // S1 state
  logic              s1_valid;
  logic              s1_sign;
  logic [23:0]       s1_mant;
  logic signed [9:0] s1_shift;
  logic              s1_rnd;
  fp_class_e         s1_cls;

  // S2 state
  logic              s2_valid;
  logic              s2_sign;
  logic [W-1:0]      s2_mag;
  logic              s2_guard;
  logic              s2_sticky;
  logic              s2_ovf;
  logic              s2_rnd;
  fp_class_e         s2_cls;

  // Output state
  logic              out_valid_q;
  logic [W-1:0]      out_data_q;
  logic [2:0]        out_flags_q;

  // S1 combinational
  logic [FpExpBits-1:0]  in_exp;
  logic [FpMantBits-1:0] in_mant;
  fp_class_e             in_cls;
  logic signed [9:0]     shift_d;

  always_comb begin
    in_exp  = bus.in_data[30:23];
    in_mant = bus.in_data[22:0];
    in_cls  = fp_classify(in_exp, in_mant);
    shift_d = $signed({2'b00, in_exp}) + ShiftOfs;
  end

  // S2 combinational: align into a wide magnitude so overflow is never lost.
  logic [WW-1:0] wide;
  logic [49:0]   rsh;
  logic [9:0]    rsh_amt;
  logic          guard_c;
  logic          sticky_c;
  logic          big_c;
  logic          pre_ovf;

  always_comb begin
    wide     = '0;
    rsh      = '0;
    rsh_amt  = -s1_shift;
    guard_c  = 1'b0;
    sticky_c = 1'b0;
    big_c    = 1'b0;
    if (s1_cls == ClsNorm) begin
      if (!s1_shift[9]) begin
        if (s1_shift >= WSigned) begin
          big_c = 1'b1;
        end else begin
          wide = WW'(s1_mant) << s1_shift[6:0];
        end
      end else if (rsh_amt >= 10'd26) begin
        // Everything lands below the guard position; only stickiness survives.
        sticky_c = 1'b1;
      end else begin
        rsh      = {s1_mant, 26'b0} >> rsh_amt[4:0];
        wide     = WW'(rsh[49:26]);
        guard_c  = rsh[25];
        sticky_c = |rsh[24:0];
      end
    end
    pre_ovf = big_c || (|wide[WW-1:W]);
  end

  // S3 combinational
  logic [W-1:0] rs_data;
  logic [2:0]   rs_flags;

  fp_round_sat #(
    .W (W)
  ) u_round_sat (
    .sign     (s2_sign),
    .mag      (s2_mag),
    .guard    (s2_guard),
    .sticky   (s2_sticky),
    .ovf_in   (s2_ovf || (s2_cls == ClsInf)),
    .nan      (s2_cls == ClsNan),
    .normal   (s2_cls == ClsNorm),
    .rnd_mode (s2_rnd),
    .data     (rs_data),
    .flags    (rs_flags)
  );

  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_mant     <= '0;
      s1_shift    <= '0;
      s1_rnd      <= 1'b0;
      s1_cls      <= ClsZero;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_mag      <= '0;
      s2_guard    <= 1'b0;
      s2_sticky   <= 1'b0;
      s2_ovf      <= 1'b0;
      s2_rnd      <= 1'b0;
      s2_cls      <= ClsZero;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign  <= bus.in_data[31];
        s1_mant  <= {1'b1, in_mant};
        s1_shift <= shift_d;
        s1_rnd   <= bus.rnd_mode;
        s1_cls   <= in_cls;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign   <= s1_sign;
        s2_mag    <= wide[W-1:0];
        s2_guard  <= guard_c;
        s2_sticky <= sticky_c;
        s2_ovf    <= pre_ovf;
        s2_rnd    <= s1_rnd;
        s2_cls    <= s1_cls;
      end
      out_valid_q <= s2_valid;
      if (s2_valid) begin
        out_data_q  <= rs_data;
        out_flags_q <= rs_flags;
      end
    end
  end

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// Directed bench for float_to_fixed_pipe with INT_BITS=1, FRAC_BITS=20 (W=22),
// two's complement output.
module tb_float_to_fixed_pipe;

  localparam int unsigned W = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  float_to_fixed_pipe_if #(.W(W)) bus ();

  float_to_fixed_pipe #(
    .INT_BITS  (1),
    .FRAC_BITS (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]  f;
    logic         rnd;
    logic [W-1:0] d;
    logic [2:0]   fl;
  } vec_t;

  // Drives one word, waits (bounded) for its result; lat counts clock edges from acceptance.
  task automatic convert(input logic [31:0] f, input logic rnd,
                         output logic [W-1:0] d, output logic [2:0] fl, output int lat);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = f;
    bus.rnd_mode  = rnd;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d  = bus.out_data;
    fl = bus.out_flags;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.rnd_mode  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== '0) begin
      n_fail++; $display("FAIL reset_out_data: got %h, expected 0", bus.out_data);
    end
    n_checks++;
    if (bus.out_flags !== 3'b000) begin
      n_fail++; $display("FAIL reset_out_flags: got %b, expected 000", bus.out_flags);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] d;
    logic [2:0]   fl;
    int           lat;
    convert(32'h3F80_0000, 1'b0, d, fl, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL basic_latency: got %0d, expected 3", lat);
    end
    n_checks++;
    if (d !== 22'h100000) begin
      n_fail++; $display("FAIL basic_data: got %h, expected 100000", d);
    end
    n_checks++;
    if (fl !== 3'b000) begin
      n_fail++; $display("FAIL basic_flags: got %b, expected 000", fl);
    end
  endtask

  task automatic test_vectors();
    vec_t         v[$];
    logic [W-1:0] d;
    logic [2:0]   fl;
    int           lat;
    v.push_back('{32'hBF00_0000, 1'b0, 22'h380000, 3'b000});  // -0.5
    v.push_back('{32'hC000_0000, 1'b0, 22'h200000, 3'b000});  // -2.0, exact min
    v.push_back('{32'h4040_0000, 1'b0, 22'h1FFFFF, 3'b010});  // 3.0 saturates
    v.push_back('{32'h3500_0000, 1'b0, 22'h000000, 3'b001});  // half LSB ties to 0
    v.push_back('{32'h3540_0000, 1'b0, 22'h000001, 3'b000});  // 0.75 LSB up
    v.push_back('{32'h3540_0000, 1'b1, 22'h000000, 3'b001});  // 0.75 LSB truncated
    v.push_back('{32'h7FC0_0000, 1'b0, 22'h000000, 3'b100});  // NaN
    v.push_back('{32'hFF80_0000, 1'b0, 22'h200000, 3'b010});  // -inf
    v.push_back('{32'h7F80_0000, 1'b0, 22'h1FFFFF, 3'b010});  // +inf
    v.push_back('{32'h0000_0001, 1'b0, 22'h000000, 3'b000});  // subnormal
    v.push_back('{32'h8000_0000, 1'b0, 22'h000000, 3'b000});  // -0.0
    v.push_back('{32'h35C0_0000, 1'b0, 22'h000002, 3'b000});  // 1.5 LSB ties to 2
    v.push_back('{32'h3620_0000, 1'b0, 22'h000002, 3'b000});  // 2.5 LSB ties to 2
    v.push_back('{32'h4F00_0000, 1'b0, 22'h1FFFFF, 3'b010});  // 2^31, far left shift
    v.push_back('{32'h3FFF_FFFF, 1'b0, 22'h1FFFFF, 3'b010});  // rounds past max
    v.push_back('{32'h3FFF_FFFF, 1'b1, 22'h1FFFFF, 3'b000});  // truncates to max
    v.push_back('{32'hBFFF_FFFF, 1'b0, 22'h200000, 3'b000});  // rounds onto min
    v.push_back('{32'h3F00_0000, 1'b0, 22'h080000, 3'b000});  // 0.5
    foreach (v[i]) begin
      convert(v[i].f, v[i].rnd, d, fl, lat);
      n_checks++;
      if (d !== v[i].d) begin
        n_fail++;
        $display("FAIL vec%0d_data (in %h rnd %b): got %h, expected %h", i, v[i].f, v[i].rnd,
                 d, v[i].d);
      end
      n_checks++;
      if (fl !== v[i].fl) begin
        n_fail++;
        $display("FAIL vec%0d_flags (in %h rnd %b): got %b, expected %b", i, v[i].f, v[i].rnd,
                 fl, v[i].fl);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  fin[4]  = '{32'h3F80_0000, 32'hBF00_0000, 32'h3E80_0000, 32'hC000_0000};
    logic [W-1:0] fexp[4] = '{22'h100000, 22'h380000, 22'h040000, 22'h200000};
    int sent = 0;
    int got  = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      bus.in_valid = (sent < 4);
      bus.in_data  = (sent < 4) ? fin[sent] : 32'h0;
      bus.rnd_mode = 1'b0;
      #1;
      if (bus.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_checks++;
        if (got >= 4 || bus.out_data !== fexp[got % 4]) begin
          n_fail++;
          $display("FAIL b2b_data%0d: got %h, expected %h", got, bus.out_data, fexp[got % 4]);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (got !== 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d, expected 4", got);
    end
    n_checks++;
    if (first_cyc !== 3 || last_cyc !== 6) begin
      n_fail++;
      $display("FAIL b2b_timing: got cycles %0d..%0d, expected 3..6", first_cyc, last_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]  fin[6]  = '{32'h3F80_0000, 32'hBF00_0000, 32'h4040_0000,
                              32'hC000_0000, 32'h3F00_0000, 32'h3E80_0000};
    logic [W-1:0] fexp[6] = '{22'h100000, 22'h380000, 22'h1FFFFF,
                              22'h200000, 22'h080000, 22'h040000};
    int sent = 0;
    int got  = 0;
    int held_at_fall = -1;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         stall;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc < 8);
      bus.in_valid  = (sent < 6);
      bus.in_data   = (sent < 6) ? fin[sent] : 32'h0;
      bus.rnd_mode  = 1'b0;
      #1;
      stall = bus.out_valid && !bus.out_ready;
      if (stall) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready cyc%0d: got %b, expected 0", cyc, bus.in_ready);
        end
        if (held_at_fall < 0) held_at_fall = sent - got;
        if (prev_stall) begin
          n_checks++;
          if (bus.out_data !== prev_data) begin
            n_fail++;
            $display("FAIL bp_stable cyc%0d: got %h, expected %h", cyc, bus.out_data, prev_data);
          end
        end
      end
      prev_stall = stall;
      prev_data  = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (got >= 6 || bus.out_data !== fexp[got % 6]) begin
          n_fail++;
          $display("FAIL bp_data%0d: got %h, expected %h", got, bus.out_data, fexp[got % 6]);
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++;
    if (held_at_fall !== 3) begin
      n_fail++; $display("FAIL bp_held_words: got %0d, expected 3", held_at_fall);
    end
    n_checks++;
    if (got !== 6) begin
      n_fail++; $display("FAIL bp_count: got %0d, expected 6", got);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0]  fin[3] = '{32'h3F80_0000, 32'hBF00_0000, 32'h4040_0000};
    logic [W-1:0] d;
    logic [2:0]   fl;
    int           lat;
    int           stale = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = fin[i];
      bus.rnd_mode = 1'b0;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre_valid: got %b, expected 1", bus.out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_out_valid: got %b, expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== '0) begin
      n_fail++; $display("FAIL rstmid_out_data: got %h, expected 0", bus.out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_fail++; $display("FAIL rstmid_stale: got %0d words, expected 0", stale);
    end
    convert(32'h3F80_0000, 1'b0, d, fl, lat);
    n_checks++;
    if (d !== 22'h100000 || fl !== 3'b000 || lat !== 3) begin
      n_fail++;
      $display("FAIL rstmid_after: got %h/%b lat %0d, expected 100000/000 lat 3", d, fl, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
